// File: rtl/minirisc_exec.sv
// Purpose : mini-RISC execution core with register file, Z/C flags, optional shift-add MUL and HALT.
// Latency : one cycle per instruction; MUL holds the core for DATA_W enabled cycles after accept.
// Backpressure: instr_ready = ena & IDLE; instr_valid while not ready is ignored, the source holds.
// Option  : define MINIRISC_MUL_EN to build the iterative multiplier (opcode A); otherwise A is a NOP.
module minirisc_exec #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              flag_z,
    output logic              flag_c,
    output logic              halted
);

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_HALT} state_e;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_MUL  = 4'hA;
    localparam logic [3:0] OP_OUT  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] rf_q [4];
    logic [DATA_W-1:0] result_q;
    logic              result_vld_q;
    logic              flag_z_q, flag_c_q;

    logic              accept;
    logic [3:0]        opcode;
    logic [1:0]        rd_idx, rs_idx;
    logic [DATA_W-1:0] rd_val, rs_val;
    logic [DATA_W:0]   add_full, sub_full;

    logic              wr_en;
    logic [1:0]        wr_idx;
    logic [DATA_W-1:0] wr_val;
    logic              c_upd, c_val;
    logic              out_en;

    logic              mul_done;
    logic [DATA_W-1:0] mul_lo;
    logic              mul_hi_nz;
    logic [1:0]        mul_wr_idx;

    // Register indices wrap modulo NREGS; with two registers only the low bit selects.
    assign opcode   = instr[15:12];
    assign rd_idx   = (NREGS == 2) ? {1'b0, instr[10]} : instr[11:10];
    assign rs_idx   = (NREGS == 2) ? {1'b0, instr[8]}  : instr[9:8];
    assign rd_val   = rf_q[rd_idx];
    assign rs_val   = rf_q[rs_idx];
    assign add_full = {1'b0, rd_val} + {1'b0, rs_val};
    assign sub_full = {1'b0, rd_val} - {1'b0, rs_val};
    assign accept   = instr_valid & instr_ready;

`ifdef MINIRISC_MUL_EN
    localparam int CW = $clog2(DATA_W + 1);

    logic [2*DATA_W-1:0] mcand_q, acc_q, acc_step;
    logic [DATA_W-1:0]   mplier_q;
    logic [CW-1:0]       cnt_q;
    logic [1:0]          mul_rd_q;
    logic                mul_step;

    assign mul_step   = ena && (state_q == ST_MUL);
    assign acc_step   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mul_done   = mul_step && (cnt_q == CW'(1));
    assign mul_lo     = acc_step[DATA_W-1:0];
    assign mul_hi_nz  = |acc_step[2*DATA_W-1:DATA_W];
    assign mul_wr_idx = mul_rd_q;

    // Shift-add multiplier: operands latched at accept, one partial-product step per enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            mul_rd_q <= '0;
        end else if (accept && opcode == OP_MUL) begin
            mcand_q  <= (2*DATA_W)'(rd_val);
            mplier_q <= rs_val;
            acc_q    <= '0;
            cnt_q    <= CW'(DATA_W);
            mul_rd_q <= rd_idx;
        end else if (mul_step) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
        end
    end
`else
    assign mul_done   = 1'b0;
    assign mul_lo     = '0;
    assign mul_hi_nz  = 1'b0;
    assign mul_wr_idx = '0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: MUL and HALT entered on accept; HALT only exits through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && opcode == OP_HALT) state_d = ST_HALT;
`ifdef MINIRISC_MUL_EN
                else if (accept && opcode == OP_MUL) state_d = ST_MUL;
`endif
            end
            ST_MUL:  if (mul_done) state_d = ST_IDLE;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: ready only while enabled and idle.
    always_comb begin
        instr_ready = ena && (state_q == ST_IDLE);
        halted      = (state_q == ST_HALT);
    end

    // Decode/execute: register write, carry update and OUT capture for the accepted instruction.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = rd_idx;
        wr_val = rd_val;
        c_upd  = 1'b0;
        c_val  = flag_c_q;
        out_en = 1'b0;
        if (mul_done) begin
            wr_en  = 1'b1;
            wr_idx = mul_wr_idx;
            wr_val = mul_lo;
            c_upd  = 1'b1;
            c_val  = mul_hi_nz;
        end else if (accept) begin
            case (opcode)
                OP_LDI: begin wr_en = 1'b1; wr_val = DATA_W'(instr[7:0]); end
                OP_MOV: begin wr_en = 1'b1; wr_val = rs_val; end
                OP_ADD: begin
                    wr_en = 1'b1; wr_val = add_full[DATA_W-1:0];
                    c_upd = 1'b1; c_val  = add_full[DATA_W];
                end
                OP_SUB: begin
                    wr_en = 1'b1; wr_val = sub_full[DATA_W-1:0];
                    c_upd = 1'b1; c_val  = sub_full[DATA_W];
                end
                OP_AND: begin wr_en = 1'b1; wr_val = rd_val & rs_val; end
                OP_OR:  begin wr_en = 1'b1; wr_val = rd_val | rs_val; end
                OP_XOR: begin wr_en = 1'b1; wr_val = rd_val ^ rs_val; end
                OP_SHL: begin
                    wr_en = 1'b1; wr_val = rd_val << 1;
                    c_upd = 1'b1; c_val  = rd_val[DATA_W-1];
                end
                OP_SHR: begin
                    wr_en = 1'b1; wr_val = rd_val >> 1;
                    c_upd = 1'b1; c_val  = rd_val[0];
                end
                OP_OUT: out_en = 1'b1;
                default: ;
            endcase
        end
    end

    // Register file write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) rf_q[i] <= '0;
        end else if (wr_en) begin
            rf_q[wr_idx] <= wr_val;
        end
    end

    // Flags: Z follows every register write, C only on the ops that define it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            if (wr_en) flag_z_q <= (wr_val == '0);
            if (c_upd) flag_c_q <= c_val;
        end
    end

    // OUT capture: result holds until the next OUT, valid is a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q     <= '0;
            result_vld_q <= 1'b0;
        end else begin
            result_vld_q <= out_en;
            if (out_en) result_q <= rd_val;
        end
    end

    assign result       = result_q;
    assign result_valid = result_vld_q;
    assign flag_z       = flag_z_q;
    assign flag_c       = flag_c_q;

endmodule

// File: doc/minirisc_exec.md
# minirisc_exec

Parametrised execution core for the next-generation mini-RISC tile. It accepts one 16-bit instruction per handshake, executes it against an internal register file and flag pair, and emits explicit OUT results. It sits behind the top-level pin wrapper, which assembles instructions from `ui_in`/`uio_in` and drives `uo_out` from `result`. It adds configurable data width, a valid/ready handshake, carry/zero flags, an iterative multiplier and a halt state.

## Interface
- `DATA_W`, 8: datapath and register width; legal range 8..32.
- `NREGS`, 4: number of registers; fixed field width is 2 bits, legal values 2 or 4.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ena` input 1: tile enable; when 0, nothing is accepted and all state freezes.
- `instr_valid` input 1: `instr` is presented.
- `instr` input 16: `[15:12]` opcode, `[11:10]` rd, `[9:8]` rs, `[7:0]` imm.
- `instr_ready` output 1: core can accept this cycle.
- `result` output DATA_W: last OUT value.
- `result_valid` output 1: one-cycle pulse per OUT.
- `flag_z`, `flag_c` output 1: zero and carry flags.
- `halted` output 1: core is in HALT.

## Operation
- Accept happens on a rising edge with `instr_valid & instr_ready & ena`.
- `instr_ready` = `ena` AND state==IDLE (combinational).
- Opcodes:
  - 0 NOP; 1 LDI rd←zext(imm); 2 MOV rd←rs.
  - 3 ADD rd←rd+rs; 4 SUB rd←rd−rs.
  - 5 AND, 6 OR, 7 XOR: rd←rd op rs.
  - 8 SHL rd←rd<<1; 9 SHR rd←rd>>1 (logical).
  - A MUL; B OUT result←rd; C–E reserved, executed as NOP; F HALT.
- rd/rs index modulo NREGS.
- Flags:
  - Every register write updates Z = (written value == 0).
  - C is updated only by the following: ADD carry-out; SUB borrow (rs>rd); SHL old MSB; SHR old LSB; MUL (upper half nonzero).
  - LDI, MOV, AND, OR and XOR leave C unchanged.
  - NOP, OUT and HALT change no flags.
- Arithmetic is modulo 2^DATA_W. Imm is zero-extended; for DATA_W>8 the upper bits are 0.
- State machine:
  - IDLE → MUL on accept of MUL.
  - MUL → IDLE after DATA_W shift-add steps.
  - IDLE → HALT on accept of HALT.
  - HALT is left only by reset.
- MUL:
  - Latches rd and rs values at accept.
  - Each active cycle: one shift-add step, counter decrements.
  - On the final step: rd←low DATA_W bits of the product; Z and C updated.
  - Later instructions are not accepted until IDLE, so no hazard exists.
- `ena`=0 during MUL: the counter and partial product hold.
- Reset (any time, including mid-MUL): state IDLE, all registers 0, `result`=0, `result_valid`=0, `flag_z`=0, `flag_c`=0, `halted`=0. `instr_ready` follows `ena` once `rst_n` is deasserted.

## Timing
- Single-cycle ops: the register and flags are visible the cycle after the accepting edge; back-to-back accepts are allowed; rs reads see the previous instruction's write.
- OUT: `result` and `result_valid` are registered at the accepting edge. `result_valid` is high for exactly one cycle; back-to-back OUTs give consecutive pulses. `result` holds until the next OUT.
- MUL: `instr_ready` is low for exactly DATA_W enabled cycles after the accept. rd is written at the edge ending the last step, and `instr_ready` returns high in the following cycle.
- HALT: `halted`=1 from the cycle after the accept; `instr_ready`=0 thereafter.
- `instr_valid` while not ready: ignored, with no side effects; the source must hold the instruction.

## Configuration
- `MINIRISC_MUL_EN` defined: MUL behaves as above, using a DATA_W-cycle shift-add unit.
- Not defined: opcode A executes as a single-cycle NOP, with no state change and no MUL state; the multiplier logic is absent.

## Test plan
- Reset with `ena`=1 → all outputs 0, `instr_ready`=1 on the first cycle after `rst_n` rises.
- DATA_W=8:
  - Stimulus: LDI r0,F0; LDI r1,20; ADD r0,r1; OUT r0.
  - Response: `result`=10 with one `result_valid` pulse; C=1, Z=0.
- SUB r1,r1 (r1=20) → r1=00, Z=1, C=0; then SHR r1 → C=0, Z=1.
- With `MINIRISC_MUL_EN`, DATA_W=8:
  - Stimulus: LDI r2,0D; LDI r3,15; MUL r2,r3; OUT r2.
  - Response: `instr_ready` low for 8 cycles, `result`=11, C=1.
  - Without the macro: MUL is a 1-cycle NOP and `result`=0D.
- `ena` dropped for 3 cycles mid-MUL → MUL completes 3 cycles later with the same product. `rst_n` pulsed mid-MUL → IDLE, r2=0, `instr_ready`=1.
- HALT followed by valid OUT instructions → `halted`=1, `instr_ready`=0, no `result_valid` pulses; reset clears `halted`.
